// File: rtl/multi_port_fifo_pkg.sv
// Shared width helpers and clamp function for the multi-push / multi-pop FIFO.
package multi_port_fifo_pkg;

  function automatic int push_ct_w(input int push_width);
    return $clog2(push_width) + 32'sd1;
  endfunction

  function automatic int pop_ct_w(input int pop_width);
    return $clog2(pop_width) + 32'sd1;
  endfunction

  // A single-entry buffer still needs a 1-bit pointer.
  function automatic int addr_w(input int elements);
    return (elements > 32'sd1) ? $clog2(elements) : 32'sd1;
  endfunction

  function automatic int occ_w(input int elements);
    return $clog2(elements + 32'sd1);
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/multi_port_fifo_if.sv
// Push/pop bus of the multi-port FIFO; the FIFO takes the slave modport.
interface multi_port_fifo_if
  import multi_port_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PUSH_WIDTH = 4,
  parameter int POP_WIDTH  = 2,
  parameter int ELEMENTS   = 15
);
  localparam int PUSH_CT_W = push_ct_w(PUSH_WIDTH);
  localparam int POP_CT_W  = pop_ct_w(POP_WIDTH);
  localparam int OCC_W     = occ_w(ELEMENTS);

  logic                           flush;
  logic [DATA_WIDTH*PUSH_WIDTH-1:0] din;
  logic [PUSH_CT_W-1:0]           din_valid_ct;
  logic [PUSH_CT_W-1:0]           din_ready_ct;
  logic [DATA_WIDTH*POP_WIDTH-1:0]  dout;
  logic [POP_CT_W-1:0]            dout_valid_ct;
  logic [POP_CT_W-1:0]            dout_ready_ct;
  logic [OCC_W-1:0]               occupancy;

  modport master (
    output flush, din, din_valid_ct, dout_ready_ct,
    input  din_ready_ct, dout, dout_valid_ct, occupancy
  );

  modport slave (
    input  flush, din, din_valid_ct, dout_ready_ct,
    output din_ready_ct, dout, dout_valid_ct, occupancy
  );
endinterface

// File: rtl/multi_port_fifo_ptr_add.sv
// fifo_ptr_add: modular pointer adder, (ptr + inc) mod ELEMENTS with one conditional subtract.
module fifo_ptr_add #(
  parameter int ELEMENTS   = 15,
  parameter int ADDR_WIDTH = 4
) (
  input  logic [ADDR_WIDTH-1:0] ptr,
  input  logic [ADDR_WIDTH:0]   inc,
  output logic [ADDR_WIDTH-1:0] sum
);
  localparam logic [ADDR_WIDTH:0] ELEMS_EXT = (ADDR_WIDTH + 1)'(ELEMENTS);

  logic [ADDR_WIDTH:0] raw_s;

  // inc never exceeds ELEMENTS, so one subtract brings the sum back in range
  always_comb begin
    raw_s = {1'b0, ptr} + inc;
    if (raw_s >= ELEMS_EXT) begin
      sum = ADDR_WIDTH'(raw_s - ELEMS_EXT);
    end else begin
      sum = ADDR_WIDTH'(raw_s);
    end
  end
endmodule

// File: rtl/multi_port_fifo.sv
// Multi-push / multi-pop FIFO using all ELEMENTS slots.
// Define MULTI_PORT_FIFO_BYPASS_EN to let the output window reach into din when nearly empty.
module multi_port_fifo
  import multi_port_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int PUSH_WIDTH = 4,
  parameter int POP_WIDTH  = 2,
  parameter int ELEMENTS   = 15
) (
  input logic             clk,
  input logic             rst,
  multi_port_fifo_if.slave bus
);
  localparam int PUSH_CT_W = push_ct_w(PUSH_WIDTH);
  localparam int POP_CT_W  = pop_ct_w(POP_WIDTH);
  localparam int AW        = addr_w(ELEMENTS);
  localparam int OCC_W     = occ_w(ELEMENTS);
  localparam int INC_W     = AW + 1;

  logic [DATA_WIDTH-1:0] mem_r [ELEMENTS];
  logic [AW-1:0]         rd_ptr_r;
  logic [AW-1:0]         wr_ptr_r;
  logic [OCC_W-1:0]      count_r;

  logic [AW-1:0]         rd_nxt_s;
  logic [AW-1:0]         wr_nxt_s;
  logic [AW-1:0]         rd_addr_s [POP_WIDTH];
  logic [AW-1:0]         wr_addr_s [PUSH_WIDTH];
  logic [INC_W-1:0]      push_inc_s;
  logic [INC_W-1:0]      pop_inc_s;
  logic [DATA_WIDTH*POP_WIDTH-1:0] dout_s;

  int cnt_i_s;
  int ready_i_s;
  int pushes_i_s;
  int valid_i_s;
  int pops_i_s;

  // Handshake counts; ready looks only at registered count so a same-cycle pop frees nothing
  always_comb begin
    cnt_i_s = int'(count_r);
    if (bus.flush) begin
      ready_i_s = 32'sd0;
    end else begin
      ready_i_s = min2(PUSH_WIDTH, ELEMENTS - cnt_i_s);
    end
    pushes_i_s = min2(int'(bus.din_valid_ct), ready_i_s);
    if (bus.flush) begin
      valid_i_s = 32'sd0;
    end else begin
`ifdef MULTI_PORT_FIFO_BYPASS_EN
      valid_i_s = min2(POP_WIDTH, cnt_i_s + pushes_i_s);
`else
      valid_i_s = min2(POP_WIDTH, cnt_i_s);
`endif
    end
    pops_i_s   = min2(int'(bus.dout_ready_ct), valid_i_s);
    push_inc_s = INC_W'(pushes_i_s);
    pop_inc_s  = INC_W'(pops_i_s);
  end

  fifo_ptr_add #(.ELEMENTS(ELEMENTS), .ADDR_WIDTH(AW)) u_rd_add (
    .ptr(rd_ptr_r), .inc(pop_inc_s), .sum(rd_nxt_s)
  );

  fifo_ptr_add #(.ELEMENTS(ELEMENTS), .ADDR_WIDTH(AW)) u_wr_add (
    .ptr(wr_ptr_r), .inc(push_inc_s), .sum(wr_nxt_s)
  );

  for (genvar k = 0; k < POP_WIDTH; k++) begin : g_rd_lane
    fifo_ptr_add #(.ELEMENTS(ELEMENTS), .ADDR_WIDTH(AW)) u_add (
      .ptr(rd_ptr_r), .inc(INC_W'(k)), .sum(rd_addr_s[k])
    );
  end

  for (genvar j = 0; j < PUSH_WIDTH; j++) begin : g_wr_lane
    fifo_ptr_add #(.ELEMENTS(ELEMENTS), .ADDR_WIDTH(AW)) u_add (
      .ptr(wr_ptr_r), .inc(INC_W'(j)), .sum(wr_addr_s[j])
    );
  end

  // Output window: storage lanes, optionally extended with incoming words
  always_comb begin
    dout_s = {(DATA_WIDTH*POP_WIDTH){1'b0}};
    for (int k = 0; k < POP_WIDTH; k++) begin
`ifdef MULTI_PORT_FIFO_BYPASS_EN
      if (!bus.flush && (k >= cnt_i_s) && ((k - cnt_i_s) < PUSH_WIDTH)) begin
        dout_s[k*DATA_WIDTH +: DATA_WIDTH] = bus.din[(k - cnt_i_s)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
        dout_s[k*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_addr_s[k]];
      end
`else
      dout_s[k*DATA_WIDTH +: DATA_WIDTH] = mem_r[rd_addr_s[k]];
`endif
    end
  end

  assign bus.dout          = dout_s;
  assign bus.din_ready_ct  = PUSH_CT_W'(ready_i_s);
  assign bus.dout_valid_ct = POP_CT_W'(valid_i_s);
  assign bus.occupancy     = count_r;

  // Pointer and count state; reset beats flush, flush beats push/pop
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {OCC_W{1'b0}};
    end else if (bus.flush) begin
      rd_ptr_r <= {AW{1'b0}};
      wr_ptr_r <= {AW{1'b0}};
      count_r  <= {OCC_W{1'b0}};
    end else begin
      rd_ptr_r <= rd_nxt_s;
      wr_ptr_r <= wr_nxt_s;
      count_r  <= OCC_W'(cnt_i_s + pushes_i_s - pops_i_s);
    end
  end

  // Storage writes; bypassed words are still stored and retired by the rd_ptr advance
  always_ff @(posedge clk) begin
    for (int j = 0; j < PUSH_WIDTH; j++) begin
      if (!rst && (j < pushes_i_s)) begin
        mem_r[wr_addr_s[j]] <= bus.din[j*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end
endmodule

// File: tb/tb_multi_port_fifo.sv
// Self-checking bench for multi_port_fifo: queue reference model plus directed literal checks.
module tb_multi_port_fifo;
  localparam int DW = 32;
  localparam int PW = 4;
  localparam int OW = 2;
  localparam int EL = 15;

  logic clk;
  logic rst;
  logic chk_en;
  int   total;
  int   bad;
  logic [DW-1:0] q[$];

  multi_port_fifo_if #(.DATA_WIDTH(DW), .PUSH_WIDTH(PW), .POP_WIDTH(OW), .ELEMENTS(EL)) bus ();

  multi_port_fifo #(.DATA_WIDTH(DW), .PUSH_WIDTH(PW), .POP_WIDTH(OW), .ELEMENTS(EL)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  function automatic int mmin(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int exp_ready();
    return bus.flush ? 0 : mmin(PW, EL - q.size());
  endfunction

  function automatic int exp_pushes();
    return mmin(int'(bus.din_valid_ct), exp_ready());
  endfunction

  function automatic int exp_valid();
`ifdef MULTI_PORT_FIFO_BYPASS_EN
    return bus.flush ? 0 : mmin(OW, q.size() + exp_pushes());
`else
    return bus.flush ? 0 : mmin(OW, q.size());
`endif
  endfunction

  function automatic logic [DW-1:0] din_word(input int i);
    return bus.din[i*DW +: DW];
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: queue of stored words, advanced on every clock edge
  always @(posedge clk) begin
    if (rst || bus.flush) begin
      q.delete();
    end else begin
      int p;
      int pp;
      p  = exp_pushes();
      pp = mmin(int'(bus.dout_ready_ct), exp_valid());
      for (int i = 0; i < p; i++) q.push_back(din_word(i));
      for (int i = 0; i < pp; i++) void'(q.pop_front());
    end
  end

  // Compare every cycle on the falling edge
  always @(negedge clk) begin
    if (chk_en && !rst) begin
      int v;
      int sz;
      logic [DW-1:0] w;
      v  = exp_valid();
      sz = q.size();
      check("din_ready_ct", 32'(bus.din_ready_ct), exp_ready());
      check("dout_valid_ct", 32'(bus.dout_valid_ct), v);
      check("occupancy", 32'(bus.occupancy), sz);
      for (int k = 0; k < v; k++) begin
        w = (k < sz) ? q[k] : din_word(k - sz);
        check("dout_word", bus.dout[k*DW +: DW], w);
      end
    end
  end

  task automatic drive(input int vct, input logic [DW-1:0] w0, input logic [DW-1:0] w1,
                       input logic [DW-1:0] w2, input logic [DW-1:0] w3,
                       input int rct, input logic fl);
    bus.din           = {w3, w2, w1, w0};
    bus.din_valid_ct  = 3'(vct);
    bus.dout_ready_ct = 2'(rct);
    bus.flush         = fl;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  localparam logic [DW-1:0] Z = 32'h0;

  initial begin
    int n;
    clk = 1'b0; rst = 1'b1; chk_en = 1'b0; total = 0; bad = 0;
    bus.din = '0; bus.din_valid_ct = 3'd0; bus.dout_ready_ct = 2'd0; bus.flush = 1'b0;
    tick(); tick();
    rst = 1'b0; chk_en = 1'b1;

    drive(0, Z, Z, Z, Z, 0, 1'b0);
    check("rst_ready", 32'(bus.din_ready_ct), 32'd4);
    check("rst_valid", 32'(bus.dout_valid_ct), 32'd0);
    check("rst_occ", 32'(bus.occupancy), 32'd0);
    tick();

    // push A..D, then keep filling to full
    drive(4, 32'hA, 32'hB, 32'hC, 32'hD, 0, 1'b0);
    check("fill_ready0", 32'(bus.din_ready_ct), 32'd4);
    tick();
    drive(4, 32'h11, 32'h12, 32'h13, 32'h14, 0, 1'b0);
    check("t1_valid", 32'(bus.dout_valid_ct), 32'd2);
    check("t1_word0", bus.dout[31:0], 32'hA);
    check("t1_word1", bus.dout[63:32], 32'hB);
    check("t1_occ", 32'(bus.occupancy), 32'd4);
    check("fill_ready1", 32'(bus.din_ready_ct), 32'd4);
    tick();
    drive(4, 32'h21, 32'h22, 32'h23, 32'h24, 0, 1'b0);
    check("fill_ready2", 32'(bus.din_ready_ct), 32'd4);
    tick();
    drive(4, 32'h31, 32'h32, 32'h33, 32'h34, 0, 1'b0);
    check("fill_ready3", 32'(bus.din_ready_ct), 32'd3);
    tick();
    drive(4, 32'h41, 32'h42, 32'h43, 32'h44, 0, 1'b0);
    check("fill_ready4", 32'(bus.din_ready_ct), 32'd0);
    check("full_occ", 32'(bus.occupancy), 32'd15);
    tick();

    // full: pop 2 while offering 4
    drive(4, 32'h51, 32'h52, 32'h53, 32'h54, 2, 1'b0);
    check("full_occ_hold", 32'(bus.occupancy), 32'd15);
    check("full_pop_word0", bus.dout[31:0], 32'hA);
    tick();
    drive(0, Z, Z, Z, Z, 0, 1'b0);
    check("after_pop_occ", 32'(bus.occupancy), 32'd13);
    check("after_pop_ready", 32'(bus.din_ready_ct), 32'd2);
    check("after_pop_head", bus.dout[31:0], 32'hC);
    tick();

    // wrap-around traffic, then drain
    for (int i = 0; i < 20; i++) begin
      if ((i % 4) == 3) drive(0, Z, Z, Z, Z, 2, 1'b0);
      else drive(3, 32'h1000 + 32'(i*4), 32'h1001 + 32'(i*4), 32'h1002 + 32'(i*4), Z, 2, 1'b0);
      tick();
    end
    n = 0;
    while (q.size() > 0 && n < 20) begin
      drive(0, Z, Z, Z, Z, 2, 1'b0);
      tick();
      n++;
    end
    drive(0, Z, Z, Z, Z, 0, 1'b0);
    check("drained_occ", 32'(bus.occupancy), 32'd0);
    tick();

    // flush with 7 stored and 4 offered
    drive(4, 32'h71, 32'h72, 32'h73, 32'h74, 0, 1'b0);
    tick();
    drive(3, 32'h75, 32'h76, 32'h77, Z, 0, 1'b0);
    tick();
    drive(4, 32'hF1, 32'hF2, 32'hF3, 32'hF4, 2, 1'b1);
    check("flush_occ7", 32'(bus.occupancy), 32'd7);
    check("flush_ready", 32'(bus.din_ready_ct), 32'd0);
    check("flush_valid", 32'(bus.dout_valid_ct), 32'd0);
    tick();
    drive(0, Z, Z, Z, Z, 0, 1'b0);
    check("post_flush_occ", 32'(bus.occupancy), 32'd0);
    check("post_flush_valid", 32'(bus.dout_valid_ct), 32'd0);
    tick();
    drive(1, 32'h600D, Z, Z, Z, 0, 1'b0);
    tick();
    drive(0, Z, Z, Z, Z, 0, 1'b0);
    check("post_flush_head", bus.dout[31:0], 32'h600D);
    check("post_flush_occ1", 32'(bus.occupancy), 32'd1);
    tick();
    drive(0, Z, Z, Z, Z, 2, 1'b0);
    tick();

    // reset mid-operation with a push in flight
    drive(4, 32'h81, 32'h82, 32'h83, 32'h84, 0, 1'b0);
    tick();
    rst = 1'b1;
    drive(4, 32'h91, 32'h92, 32'h93, 32'h94, 1, 1'b0);
    tick();
    rst = 1'b0;
    drive(0, Z, Z, Z, Z, 0, 1'b0);
    check("midrst_occ", 32'(bus.occupancy), 32'd0);
    check("midrst_valid", 32'(bus.dout_valid_ct), 32'd0);
    check("midrst_ready", 32'(bus.din_ready_ct), 32'd4);
    tick();

    // push X,Y into empty FIFO while taking one
    drive(2, 32'hAAAA, 32'hBBBB, Z, Z, 1, 1'b0);
`ifdef MULTI_PORT_FIFO_BYPASS_EN
    check("byp_valid", 32'(bus.dout_valid_ct), 32'd2);
    check("byp_word0", bus.dout[31:0], 32'hAAAA);
`else
    check("nobyp_valid", 32'(bus.dout_valid_ct), 32'd0);
`endif
    tick();
    drive(0, Z, Z, Z, Z, 0, 1'b0);
`ifdef MULTI_PORT_FIFO_BYPASS_EN
    check("byp_occ", 32'(bus.occupancy), 32'd1);
    check("byp_head", bus.dout[31:0], 32'hBBBB);
`else
    check("nobyp_occ", 32'(bus.occupancy), 32'd2);
    check("nobyp_head", bus.dout[31:0], 32'hAAAA);
`endif
    tick();

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multi_port_fifo.md
Name: multi_port_fifo

Overview:
Multi-push, multi-pop FIFO. Up to PUSH_WIDTH words are accepted and up to POP_WIDTH words are delivered per cycle, so it can feed superscalar decode and dispatch lanes. It generalises the team's single-pop multi-push FIFO with:
- a multi-word output window;
- a synchronous flush for pipeline redirects;
- an explicit occupancy output;
- full use of all ELEMENTS slots, with no sacrificial slot.

Parameters:
DATA_WIDTH, 32, bits per word
PUSH_WIDTH, 4, max words pushed per cycle (>=1)
POP_WIDTH, 2, max words popped per cycle (>=1)
ELEMENTS, 15, storage depth in words (>= max(PUSH_WIDTH,POP_WIDTH); non-power-of-two allowed)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
flush  in  1  synchronous clear of contents
din  in  DATA_WIDTH*PUSH_WIDTH  push words, LSB word is oldest
din_valid_ct  in  $clog2(PUSH_WIDTH)+1  number of valid words in din (low-order words)
din_ready_ct  out  $clog2(PUSH_WIDTH)+1  number of words that can be accepted this cycle
dout  out  DATA_WIDTH*POP_WIDTH  output window, LSB word is the FIFO head
dout_valid_ct  out  $clog2(POP_WIDTH)+1  number of valid words in dout
dout_ready_ct  in  $clog2(POP_WIDTH)+1  number of words the consumer takes
occupancy  out  $clog2(ELEMENTS+1)  stored word count (registered)

Behaviour:
- Clock and reset: one clock. rst is synchronous and active-high.
- On rst: rd_ptr=0, wr_ptr=0, count=0, occupancy=0. Outputs then read din_ready_ct=min(PUSH_WIDTH,ELEMENTS) and dout_valid_ct=0 (or the bypass value, see Optional Feature). Buffer contents are not reset.
- Reset mid-operation: stored data is discarded and accepts in that cycle are ignored.
- Full depth is usable: the counter distinguishes full from empty. Pointers wrap modulo ELEMENTS (compare-and-subtract, no power-of-two masking).
- free = ELEMENTS - count.
- din_ready_ct = min(PUSH_WIDTH, free).
  - Depends only on registered state; no combinational path from dout_ready_ct.
  - Credit freed by a same-cycle pop is not reused.
- pushes = min(din_valid_ct, din_ready_ct).
  - Words din[0..pushes-1] are written to wr_ptr, wr_ptr+1, ... (mod ELEMENTS), in that order.
- Output window, without bypass: dout word k = buf[(rd_ptr+k) mod ELEMENTS] for k < count. Words k >= count are don't-care.
- dout_valid_ct = min(POP_WIDTH, count) without bypass.
- pops = min(dout_ready_ct, dout_valid_ct). dout_ready_ct above dout_valid_ct is legal and is clamped.
- Next-state update:
  - rd_ptr += pops
  - wr_ptr += pushes
  - count += pushes - pops
- Simultaneous push and pop at full: din_ready_ct is 0, so only the pop takes effect and count drops by pops.
- Simultaneous push and pop at empty: handled by bypass when enabled; otherwise only the push takes effect.
- flush (priority below rst, above push/pop):
  - next cycle: rd_ptr=wr_ptr=0, count=0;
  - same-cycle pushes and pops are discarded;
  - din_ready_ct and dout_valid_ct are driven 0 during the flush cycle.
- Latency: a pushed word is visible on dout the cycle after acceptance (0 cycles with bypass).
- Pointer arithmetic: add in ADDR_WIDTH+1 bits, then subtract ELEMENTS if the sum >= ELEMENTS. A single step suffices because the increment is <= ELEMENTS.

Optional Feature:
Macro: MULTI_PORT_FIFO_BYPASS_EN
- Defined: the window extends into din when count < POP_WIDTH.
  - dout word k = din word (k - count) for count <= k < POP_WIDTH.
  - dout_valid_ct = min(POP_WIDTH, count + pushes).
  - Bypassed words popped this cycle are still written to storage and retired by the rd_ptr advance. Pointer math is unchanged.
  - When flush=1, no bypass.
- Undefined: the window shows storage only, with 1-cycle latency, and dout has no combinational path from din.

Decomposition:
- Package multi_port_fifo_pkg:
  - width helper functions: push count width, pop count width, ADDR_WIDTH = $clog2(ELEMENTS), occupancy width;
  - a min-of-two function used by the clamps.
- Sub-module fifo_ptr_add:
  - parameterised modular adder (ptr + inc mod ELEMENTS);
  - instantiated for rd_ptr, for wr_ptr, and once per window lane for read address generation.

Test Plan:
- Reset, then push 4 words A,B,C,D (din_valid_ct=4, dout_ready_ct=0) -> next cycle dout_valid_ct=2, dout={B,A}, occupancy=4, din_ready_ct=4.
- Fill to 15 with no pops -> din_ready_ct steps 4,4,4,3,0. Then push with din_valid_ct=4 at full -> nothing accepted, occupancy stays 15.
- Full FIFO, pop 2 with din_valid_ct=4 in the same cycle -> 0 pushes accepted, occupancy=13; next cycle din_ready_ct=2.
- Wrap-around: 20 cycles of push 3 / pop 2 interleaved with drains, over ELEMENTS=15 -> output order matches the scoreboard and pointers wrap past 14 to 0.
- flush with count=7 and push 4 in the same cycle -> next cycle occupancy=0, dout_valid_ct=0, and the flushed words never appear.
- Bypass enabled, empty, push X,Y with dout_ready_ct=1 -> same cycle dout word0=X, dout_valid_ct=2; next cycle occupancy=1, head=Y.
